// File: rtl/csr_pkg.sv
// Shared definitions for the CSR read-modify-write controller: operation
// encodings, controller state encoding and default counter addresses.
package csr_pkg;

  // Operation encoding carried on req_op.
  typedef enum logic [1:0] {
    OP_RO = 2'b00,  // read only, never writes
    OP_RW = 2'b01,  // write operand
    OP_RS = 2'b10,  // set bits given by operand
    OP_RC = 2'b11   // clear bits given by operand
  } csr_op_e;

  // Controller sequence: accept, read the old value, then write back.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WB   = 2'b10
  } csr_state_e;

  // Default addresses of the cycle and retired-instruction counters.
  localparam logic [11:0] MCYCLE_ADDR_DEF   = 12'hB00;
  localparam logic [11:0] MINSTRET_ADDR_DEF = 12'hB02;

endpackage

// File: rtl/csr_alu.sv
// Combinational read-modify-write function: from the operation, the old CSR
// value and the operand, produce the new value and whether it is written.
module csr_alu
  import csr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  csr_op_e           op,
  input  logic [DATA_W-1:0] old_val,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] new_val,
  output logic              wr_en
);

  // New value and write enable; set/clear with a zero operand is a pure read.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    new_val = old_val;
    wr_en   = 1'b0;
    case (op)
      OP_RW: begin
        new_val = wdata;
        wr_en   = 1'b1;
      end
      OP_RS: begin
        new_val = old_val | wdata;
        wr_en   = |wdata;
      end
      OP_RC: begin
        new_val = old_val & ~wdata;
        wr_en   = |wdata;
      end
      default: begin
        new_val = old_val;
        wr_en   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_rmw_ctrl.sv
// CSR read-modify-write controller. Accepts one request, reads the target
// from csr_file (one-cycle read latency), then responds with the old value
// and writes back the modified value in the same cycle.
// Optional feature macro CSR_COUNTERS_EN: internal mcycle/minstret counters
// served at MCYCLE_ADDR/MINSTRET_ADDR instead of csr_file.
module csr_rmw_ctrl
  import csr_pkg::*;
#(
  parameter int                DATA_W        = 32,
  parameter int                ADDR_W        = 12,
  parameter logic [ADDR_W-1:0] MCYCLE_ADDR   = ADDR_W'(MCYCLE_ADDR_DEF),
  parameter logic [ADDR_W-1:0] MINSTRET_ADDR = ADDR_W'(MINSTRET_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              write,
  output logic [ADDR_W-1:0] wrAddr_CSR,
  output logic [DATA_W-1:0] wrVal_CSR,
  output logic [ADDR_W-1:0] rdAddr_CSR,
  input  logic [DATA_W-1:0] rdVal_CSR,
  input  logic              instret_pulse
);

  csr_state_e        state_q, state_d;
  csr_op_e           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Values held on the outputs between write-back cycles.
  logic [DATA_W-1:0] rsp_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_val_q;

  logic              in_wb;
  logic              accept;
  logic [DATA_W-1:0] old_val;
  logic [DATA_W-1:0] new_val;
  logic              alu_wr;
  logic              ext_wr;

  assign in_wb  = (state_q == ST_WB);
  assign accept = (state_q == ST_IDLE) && req_valid;

  // State register; reset aborts any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: one request walks IDLE -> RD -> WB -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_RD;
      ST_RD:   state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the request on acceptance; req_* is ignored in every other state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= OP_RO;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      op_q    <= csr_op_e'(req_op);
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  csr_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op      (op_q),
    .old_val (old_val),
    .wdata   (wdata_q),
    .new_val (new_val),
    .wr_en   (alu_wr)
  );

`ifdef CSR_COUNTERS_EN
  logic [DATA_W-1:0] mcycle_q;
  logic [DATA_W-1:0] minstret_q;
  logic              hit_mcycle;
  logic              hit_minstret;

  assign hit_mcycle   = (addr_q == MCYCLE_ADDR);
  assign hit_minstret = (addr_q == MINSTRET_ADDR);
  assign old_val      = hit_mcycle   ? mcycle_q   :
                        hit_minstret ? minstret_q : rdVal_CSR;
  // Counter writes stay internal; csr_file never sees them.
  assign ext_wr       = alu_wr && !hit_mcycle && !hit_minstret;

  // Free-running counters; a write-back to a counter wins over its increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (in_wb && alu_wr && hit_mcycle) mcycle_q <= new_val;
      else                               mcycle_q <= mcycle_q + DATA_W'(1);
      if (in_wb && alu_wr && hit_minstret) minstret_q <= new_val;
      else if (instret_pulse)              minstret_q <= minstret_q + DATA_W'(1);
    end
  end
`else
  // Counter addresses are ordinary csr_file entries; instret_pulse has no use.
  logic unused_counter_cfg;
  assign unused_counter_cfg = instret_pulse ^ (MCYCLE_ADDR == MINSTRET_ADDR);
  assign old_val            = rdVal_CSR;
  assign ext_wr             = alu_wr;
`endif

  // Hold the last response and write port values so they stay stable outside WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_q     <= '0;
      wr_addr_q <= '0;
      wr_val_q  <= '0;
    end else if (in_wb) begin
      rsp_q     <= old_val;
      wr_addr_q <= addr_q;
      wr_val_q  <= new_val;
    end
  end

  // Output drive: response and write are live only in WB, held otherwise.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    rsp_valid  = in_wb;
    write      = in_wb && ext_wr;
    rsp_rdata  = rsp_q;
    wrAddr_CSR = wr_addr_q;
    wrVal_CSR  = wr_val_q;
    rdAddr_CSR = addr_q;
    if (in_wb) begin
      rsp_rdata  = old_val;
      wrAddr_CSR = addr_q;
      wrVal_CSR  = new_val;
    end
  end

endmodule

// File: tb/tb_csr_rmw_ctrl.sv
// Self-checking bench for csr_rmw_ctrl: a behavioural csr_file responds to the
// DUT, a reference model predicts each response, and a monitor compares.
// Build with CSR_COUNTERS_EN to also exercise the internal counters.
module tb_csr_rmw_ctrl;

  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          write;
  logic [AW-1:0] wrAddr_CSR;
  logic [DW-1:0] wrVal_CSR;
  logic [AW-1:0] rdAddr_CSR;
  logic [DW-1:0] rdVal_CSR;
  logic          instret_pulse;

  csr_rmw_ctrl #(
    .DATA_W        (DW),
    .ADDR_W        (AW),
    .MCYCLE_ADDR   (12'hB00),
    .MINSTRET_ADDR (12'hB02)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .write         (write),
    .wrAddr_CSR    (wrAddr_CSR),
    .wrVal_CSR     (wrVal_CSR),
    .rdAddr_CSR    (rdAddr_CSR),
    .rdVal_CSR     (rdVal_CSR),
    .instret_pulse (instret_pulse)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Environment: csr_file with one-cycle registered read.
  bit [DW-1:0] csr_mem [4096];
  always @(posedge clk) begin
    rdVal_CSR <= csr_mem[rdAddr_CSR];
    if (write) csr_mem[wrAddr_CSR] <= wrVal_CSR;
  end

  // Reference model state: architectural CSR contents.
  bit [DW-1:0] ref_csr [4096];

  typedef struct {
    bit          chk_rdata;
    bit [DW-1:0] rdata;
    bit          exp_wr;
    bit [AW-1:0] addr;
    bit [DW-1:0] wval;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Predicts response and write effect from the operation rules.
  function automatic exp_t model(input logic [1:0] op, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wd);
    exp_t e;
    bit [DW-1:0] old;
    old         = ref_csr[addr];
    e.chk_rdata = 1'b1;
    e.rdata     = old;
    e.addr      = addr;
    e.exp_wr    = 1'b0;
    e.wval      = '0;
    e.cyc       = 0;
    case (op)
      2'b01: begin e.exp_wr = 1'b1; e.wval = wd; end
      2'b10: if (wd != 0) begin e.exp_wr = 1'b1; e.wval = old | wd; end
      2'b11: if (wd != 0) begin e.exp_wr = 1'b1; e.wval = old & ~wd; end
      default: ;
    endcase
    if (e.exp_wr) ref_csr[addr] = e.wval;
    return e;
  endfunction

  // Present a request until accepted, then queue the given expectation.
  task automatic issue_raw(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input exp_t e_in);
    exp_t e;
    int n;
    e = e_in;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
    end else begin
      e.cyc    = cyc + 2;
      last_acc = cyc;
      sb.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd);
    exp_t e;
    e = model(op, addr, wd);
    issue_raw(op, addr, wd, e);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid     = 1'b0;
    instret_pulse = 1'b0;
    reset         = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compare every response against the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (write) check("write_only_with_rsp", 32'(rsp_valid), 32'd1);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_latency", 32'(cyc), 32'(e.cyc));
          if (e.chk_rdata) check("rsp_rdata", rsp_rdata, e.rdata);
          check("write", 32'(write), 32'(e.exp_wr));
          if (e.exp_wr) begin
            check("wr_addr", 32'(wrAddr_CSR), 32'(e.addr));
            check("wr_val", wrVal_CSR, e.wval);
          end
        end
      end
    end
  end

  logic [AW-1:0] addr_pool [6] = '{12'h300, 12'h305, 12'h341, 12'h7C0, 12'h001, 12'hFFF};

  initial begin
    int a0;
    int n;
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_op        = 2'b00;
    req_addr      = '0;
    req_wdata     = '0;
    instret_pulse = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_wr_addr", 32'(wrAddr_CSR), 32'd0);
    check("rst_rd_addr", 32'(rdAddr_CSR), 32'd0);
    check("rst_wr_val", wrVal_CSR, 32'd0);

    // Set bits: 0xF0 | 0x0F -> 0xFF, old value returned.
    issue(2'b01, 12'h300, 32'h0000_00F0);
    idle(1);
    issue(2'b10, 12'h300, 32'h0000_000F);
    idle(1);
    check("rs_model_0x300", ref_csr[12'h300], 32'h0000_00FF);
    // Clear with zero operand: pure read, no write.
    issue(2'b11, 12'h300, 32'h0);
    issue(2'b00, 12'h300, 32'h0);
    idle(1);

    // Back-to-back write then read: one request every 3 cycles.
    issue(2'b01, 12'h305, 32'h0000_1234);
    a0 = last_acc;
    issue(2'b00, 12'h305, 32'h0);
    check("b2b_spacing", 32'(last_acc - a0), 32'd3);
    idle(2);

    // Reset during RD aborts the operation.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_addr  = 12'h300;
    req_wdata = 32'hDEAD_BEEF;
    check("abort_pre_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_in_rd", 32'(req_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_write", 32'(write), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready_after", 32'(req_ready), 32'd1);
    check("abort_rsp_rdata", rsp_rdata, 32'd0);
    check("abort_rd_addr", 32'(rdAddr_CSR), 32'd0);
    issue(2'b00, 12'h300, 32'h0);
    idle(1);

    // Randomized operations over a small address pool.
    for (int i = 0; i < 80; i++) begin
      logic [1:0]    op;
      logic [AW-1:0] ad;
      logic [DW-1:0] wd;
      op = 2'($urandom_range(0, 3));
      ad = addr_pool[$urandom_range(0, 5)];
      wd = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
      issue(op, ad, wd);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
    end
    idle(1);
    for (int i = 0; i < 6; i++) issue(2'b00, addr_pool[i], 32'h0);
    idle(1);

`ifdef CSR_COUNTERS_EN
    begin
      exp_t e;
      e = '{chk_rdata: 1'b0, rdata: '0, exp_wr: 1'b0, addr: 12'hB00, wval: '0, cyc: 0};
      issue_raw(2'b01, 12'hB00, 32'hFFFF_FFFF, e);
      e.chk_rdata = 1'b1;
      e.rdata     = 32'h0000_0001;
      issue_raw(2'b00, 12'hB00, 32'h0, e);
      idle(2);
      do_reset();
      @(negedge clk);
      instret_pulse = 1'b1;
      repeat (5) @(negedge clk);
      instret_pulse = 1'b0;
      e.addr  = 12'hB02;
      e.rdata = 32'h0000_0005;
      issue_raw(2'b00, 12'hB02, 32'h0, e);
      idle(2);
    end
`endif

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
